// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared types and constants for the 3x3 RGB565 filter row sequencer
package filter_pkg;

   localparam int PIX_W = 16;

   // RGB565 field positions
   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;

   localparam int DEF_BLOCK_LENGTH = 240;
   localparam int DEF_CURSOR_W     = 10;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      GAP,
      RD_WAIT,
      RD_OUT,
      DONE
   } seq_state_t;

endpackage

// File: rtl/filter_out_reg.sv
// rtl/filter_out_reg.sv - single-entry output holding register with valid/ready
module filter_out_reg
   import filter_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [PIX_W-1:0] load_data,
   input  logic             load_sol,
   input  logic             load_eol,
   input  logic             ready,
   output logic             valid,
   output logic [PIX_W-1:0] data,
   output logic             sol,
   output logic             eol
);

   // Capture a filtered pixel with its tags; hold everything until the consumer takes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
         sol   <= 1'b0;
         eol   <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         sol   <= load_sol;
         eol   <= load_eol;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/filter_row_sequencer.sv
// rtl/filter_row_sequencer.sv - row write / filtered read sequencer around the 3x3 line-buffered filter
module filter_row_sequencer
   import filter_pkg::*;
#(
   parameter int BLOCK_LENGTH = DEF_BLOCK_LENGTH,
   parameter int ROWS         = 320,
   parameter int CURSOR_W     = DEF_CURSOR_W,
   parameter int SETTLE       = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [PIX_W-1:0]    in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PIX_W-1:0]    out_data,
   output logic                out_sol,
   output logic                out_eol,
   output logic                frame_done,
   output logic                busy,
   output logic                f_wren,
   output logic [CURSOR_W-1:0] f_cursor,
   output logic [PIX_W-1:0]    f_d_in,
   input  logic                f_d_rdy,
   input  logic [PIX_W-1:0]    f_d_out
);

   localparam int IDX_W = $clog2(BLOCK_LENGTH);
   localparam int ROW_W = $clog2(ROWS + 1);
   localparam int SET_W = $clog2(SETTLE + 1);

   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BLOCK_LENGTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS);
   localparam logic [ROW_W-1:0] PRIME_ROWS = ROW_W'(3);
   localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SETTLE);

   seq_state_t       state;
   logic [IDX_W-1:0] idx;
   logic [ROW_W-1:0] row_cnt;
   logic [SET_W-1:0] settle;

   logic in_hs;
   logic out_hs;
   logic capture;

   assign in_hs    = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;
   // The filter's RAM read pipeline needs the cursor held SETTLE cycles before its output is trusted.
   assign capture  = (state == RD_WAIT) && (settle == SETTLE_MAX) && f_d_rdy;
   assign f_d_in   = in_data;
   assign f_cursor = CURSOR_W'(idx);

   // Sequencer: write rows with wren held high, then sweep the cursor once three rows are resident.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         row_cnt    <= '0;
         settle     <= '0;
         f_wren     <= 1'b0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               state    <= WRITE;
               f_wren   <= 1'b1;
               in_ready <= 1'b1;
               busy     <= 1'b1;
            end
            WRITE: begin
               if (in_hs) begin
                  if (idx == LAST_IDX) begin
                     idx      <= '0;
                     row_cnt  <= row_cnt + 1'b1;
                     f_wren   <= 1'b0;
                     in_ready <= 1'b0;
                     settle   <= '0;
                     state    <= ((row_cnt + 1'b1) < PRIME_ROWS) ? GAP : RD_WAIT;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            GAP: begin
               // One low cycle guarantees the filter sees a fresh wren rising edge per row.
               state    <= WRITE;
               f_wren   <= 1'b1;
               in_ready <= 1'b1;
            end
            RD_WAIT: begin
               if (settle != SETTLE_MAX) begin
                  settle <= settle + 1'b1;
               end else if (f_d_rdy) begin
                  state <= RD_OUT;
               end
            end
            RD_OUT: begin
               if (out_hs) begin
                  if (idx == LAST_IDX) begin
                     idx <= '0;
                     if (row_cnt == LAST_ROW) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                     end else begin
                        state <= GAP;
                     end
                  end else begin
                     idx    <= idx + 1'b1;
                     settle <= '0;
                     state  <= RD_WAIT;
                  end
               end
            end
            DONE: begin
               row_cnt <= '0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   filter_out_reg u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (capture),
      .load_data (f_d_out),
      .load_sol  (idx == '0),
      .load_eol  (idx == LAST_IDX),
      .ready     (out_ready),
      .valid     (out_valid),
      .data      (out_data),
      .sol       (out_sol),
      .eol       (out_eol)
   );

endmodule

// File: tb/tb_filter_row_sequencer.sv
// tb/tb_filter_row_sequencer.sv - directed bench for filter_row_sequencer with a behavioural filter stand-in
module tb_filter_row_sequencer;

   localparam int BL    = 240;
   localparam int NROWS = 5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = 16'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        out_sol;
   logic        out_eol;
   logic        frame_done;
   logic        busy;
   logic        f_wren;
   logic [9:0]  f_cursor;
   logic [15:0] f_d_in;
   logic        f_d_rdy = 1'b1;
   logic [15:0] f_d_out;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   filter_row_sequencer #(
      .BLOCK_LENGTH (BL),
      .ROWS         (NROWS),
      .CURSOR_W     (10),
      .SETTLE       (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sol    (out_sol),
      .out_eol    (out_eol),
      .frame_done (frame_done),
      .busy       (busy),
      .f_wren     (f_wren),
      .f_cursor   (f_cursor),
      .f_d_in     (f_d_in),
      .f_d_rdy    (f_d_rdy),
      .f_d_out    (f_d_out)
   );

   // Filter stand-in: one row of storage, three-stage cursor pipeline, inverted result, zero at cursor 0
   logic [15:0] mem [0:BL-1];
   logic [9:0]  c1 = 10'd0, c2 = 10'd0, c3 = 10'd0;

   always @(posedge clk) begin
      if (f_wren) mem[f_cursor[7:0]] <= f_d_in;
      c1 <= f_cursor;
      c2 <= c1;
      c3 <= c2;
   end

   assign f_d_out = (c3 == 10'd0) ? 16'h0 : ~mem[c3[7:0]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [15:0] pix(input int r, input int k);
      logic [15:0] kk;
      kk = 16'(k);
      if (r <= 2) return kk;
      return {4'(r), kk[11:0]};
   endfunction

   function automatic logic [15:0] exp_out(input int r, input int k);
      if (k == 0) return 16'h0;
      return ~pix(r, k);
   endfunction

   // Output monitor and downstream ready / filter ready generator
   int          mon_k = 0, frow = 0, out_rows = 0, hs_total = 0, done_cnt = 0, rises = 0, stable = 0;
   logic [9:0]  prev_cur = 10'd0;
   bit          prev_valid = 0, prev_stall = 0, prev_wren = 0, rand_ready = 0;
   logic [17:0] held = 18'h0;

   always @(negedge clk) begin
      if (reset) begin
         mon_k      = 0;
         frow       = 0;
         stable     = 0;
         prev_valid = 0;
         prev_stall = 0;
         prev_wren  = 0;
         out_ready  = 1'b1;
         f_d_rdy    = 1'b1;
      end else begin
         if (f_wren && !prev_wren) rises++;
         prev_wren = f_wren;
         if (f_cursor == prev_cur) stable++;
         else stable = 0;
         prev_cur = f_cursor;
         if (out_valid && !prev_valid) check("cursor_settled", 32'(stable >= 3), 32'd1);
         if (out_valid && prev_stall) check("stall_hold", 32'({out_data, out_sol, out_eol}), 32'(held));
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         f_d_rdy   = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (out_valid && out_ready) begin
            check("out_data", 32'(out_data), 32'(exp_out(frow + 3, mon_k)));
            check("out_sol", 32'(out_sol), 32'(mon_k == 0));
            check("out_eol", 32'(out_eol), 32'(mon_k == BL - 1));
            hs_total++;
            mon_k++;
            if (mon_k == BL) begin
               mon_k = 0;
               frow++;
               out_rows++;
            end
         end
         prev_stall = out_valid && !out_ready;
         held       = {out_data, out_sol, out_eol};
         prev_valid = out_valid;
         if (frame_done) begin
            done_cnt++;
            frow = 0;
         end
      end
   end

   task automatic send_row(input int r, input bit toggle);
      int k = 0;
      int budget = 0;
      int gaps = 0;
      bit ph = 0;
      while (k < BL && budget < 20000) begin
         @(negedge clk);
         budget++;
         if (k > 0 && !f_wren) gaps++;
         ph = toggle ? !ph : 1'b1;
         in_valid = ph;
         in_data  = ph ? pix(r, k) : 16'hDEAD;
         if (in_valid && in_ready) k++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'h0;
      check($sformatf("row%0d_sent", r), 32'(k), 32'(BL));
      check($sformatf("row%0d_wren_gaps", r), 32'(gaps), 32'd0);
   endtask

   task automatic wait_rows(input int n);
      int t = 0;
      while (out_rows < n && t < 20000) begin
         @(negedge clk);
         t++;
      end
      check($sformatf("out_rows_%0d", n), 32'(out_rows), 32'(n));
   endtask

   task automatic wait_done(input int n);
      int t = 0;
      while (done_cnt < n && t < 20000) begin
         @(negedge clk);
         t++;
      end
      check($sformatf("frame_done_%0d", n), 32'(done_cnt), 32'(n));
   endtask

   initial begin
      int r0;
      int errs;
      int t;

      // Reset values while reset is held
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_tags", 32'({out_sol, out_eol, frame_done}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_f_wren", 32'(f_wren), 32'd0);
      check("rst_f_cursor", 32'(f_cursor), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("write_in_ready", 32'(in_ready), 32'd1);
      check("write_busy", 32'(busy), 32'd1);
      check("write_f_wren", 32'(f_wren), 32'd1);

      // Frame 1: two priming rows, then three read rows
      send_row(1, 1'b0);
      send_row(2, 1'b0);
      check("rises_rows12", 32'(rises), 32'd2);
      check("no_output_rows12", 32'(hs_total), 32'd0);
      check("no_valid_rows12", 32'(out_valid), 32'd0);

      send_row(3, 1'b0);
      wait_rows(1);
      check("no_done_early", 32'(done_cnt), 32'd0);

      rand_ready = 1'b1;
      r0 = rises;
      send_row(4, 1'b1);
      check("row4_one_rise", 32'(rises - r0), 32'd1);
      errs = 0;
      for (int k = 0; k < BL; k++) if (mem[k] !== pix(4, k)) errs++;
      check("row4_mem_intact", 32'(errs), 32'd0);
      wait_rows(2);
      rand_ready = 1'b0;

      send_row(5, 1'b0);
      wait_done(1);
      check("frame1_rows", 32'(out_rows), 32'd3);
      check("frame1_pixels", 32'(hs_total), 32'(3 * BL));
      repeat (3) @(negedge clk);
      check("frame_done_once", 32'(done_cnt), 32'd1);

      // Frame 2: reset in the middle of the first read row
      send_row(1, 1'b0);
      send_row(2, 1'b0);
      send_row(3, 1'b0);
      t = 0;
      while (mon_k < 10 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      check("mid_read_reached", 32'(mon_k >= 10), 32'd1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      check("midrst_f_cursor", 32'(f_cursor), 32'd0);
      check("midrst_ctrl", 32'({busy, in_ready, f_wren, out_sol, out_eol}), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Frame 3: full frame after the interrupted one
      for (int r = 1; r <= NROWS; r++) send_row(r, 1'b0);
      wait_done(2);
      check("frame3_rows", 32'(out_rows), 32'd6);
      repeat (3) @(negedge clk);
      check("frame3_done_once", 32'(done_cnt), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
